// File: rtl/keccak_round_ctrl.sv
// Round sequencer for Keccak-f[1600]: accepts a permutation request, steps the
// round index t through the reduced-round window and hands the result off.
module keccak_round_ctrl #(
    parameter int unsigned NROUNDS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_en,
    output logic       round_en,
    output logic [4:0] t,
    output logic       last_round,
    input  logic       hold,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [4:0] T_FIRST = 5'(24 - NROUNDS);
    localparam logic [4:0] T_LAST  = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [4:0] r_t;

    logic w_in_ready;
    logic w_round_en;
    logic w_out_valid;
    logic w_load;

    // Handshake and round strobes; reset and abort silence every strobe.
    always_comb begin
        w_in_ready  = 1'b0;
        w_round_en  = 1'b0;
        w_out_valid = 1'b0;
        if (rst || abort) begin
            w_in_ready  = 1'b0;
            w_round_en  = 1'b0;
            w_out_valid = 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  w_in_ready  = 1'b1;
                S_RUN:   w_round_en  = ~hold;
                S_DONE: begin
                    w_out_valid = 1'b1;
                    w_in_ready  = out_ready;
                end
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_load     = in_valid & w_in_ready;
    assign in_ready   = w_in_ready;
    assign load_en    = w_load;
    assign round_en   = w_round_en;
    assign last_round = w_round_en & (r_t == T_LAST);
    assign out_valid  = w_out_valid;
    assign busy       = ~rst & (r_state != S_IDLE);
    assign t          = r_t;

    // State and round counter; t sits at its first value whenever not running
    // so the round-constant ROM output is already settled for the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_t     <= T_FIRST;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_t     <= T_FIRST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_RUN;
                    end
                    r_t <= T_FIRST;
                end
                S_RUN: begin
                    if (!hold) begin
                        if (r_t == T_LAST) begin
                            r_state <= S_DONE;
                            r_t     <= T_FIRST;
                        end else begin
                            r_t <= r_t + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= in_valid ? S_RUN : S_IDLE;
                    end
                    r_t <= T_FIRST;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_t     <= T_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: a 24-round and a 12-round instance.
module tb_keccak_round_ctrl;

    typedef struct packed {
        logic [4:0] t;
        logic       last;
    } rnd_t;

    logic clk;
    logic rst;

    logic       in_valid_a, in_ready_a, load_en_a, round_en_a, last_a;
    logic       hold_a, abort_a, out_valid_a, out_ready_a, busy_a;
    logic [4:0] t_a;
    logic       in_valid_b, in_ready_b, load_en_b, round_en_b, last_b;
    logic       hold_b, abort_b, out_valid_b, out_ready_b, busy_b;
    logic [4:0] t_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    rnd_t qa[$];
    rnd_t qb[$];
    int   la[$];
    int   lb[$];
    int   acc_a, acc_b;
    logic ov_prev_a, ov_prev_b;

    keccak_round_ctrl #(.NROUNDS(24)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .load_en(load_en_a), .round_en(round_en_a), .t(t_a), .last_round(last_a),
        .hold(hold_a), .abort(abort_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .busy(busy_a)
    );

    keccak_round_ctrl #(.NROUNDS(12)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .load_en(load_en_b), .round_en(round_en_b), .t(t_b), .last_round(last_b),
        .hold(hold_b), .abort(abort_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rounds(input int which, input int lo, input int hi);
        rnd_t e;
        for (int k = lo; k <= hi; k++) begin
            e.t    = 5'(k);
            e.last = (k == 23);
            if (which == 0) qa.push_back(e);
            else            qb.push_back(e);
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy_a), 32'd0);
    endtask

    task automatic wait_idle_b(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy_b), 32'd0);
    endtask

    task automatic wait_ov_a(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(out_valid_a), 32'd1);
    endtask

    // Monitor for the 24-round instance: pops expected rounds and latencies.
    always @(negedge clk) begin
        rnd_t e;
        if (rst) begin
            ov_prev_a <= 1'b0;
        end else begin
            if (load_en_a) acc_a <= cyc;
            if (round_en_a) begin
                if (qa.size() == 0) check("a_unexpected_round", 32'd1, 32'd0);
                else begin
                    e = qa.pop_front();
                    check("a_round_t", 32'(t_a), 32'(e.t));
                    check("a_last_round", 32'(last_a), 32'(e.last));
                end
            end else if (last_a) begin
                check("a_last_without_round", 32'd1, 32'd0);
            end
            if (out_valid_a && !ov_prev_a) begin
                if (la.size() == 0) check("a_unexpected_out_valid", 32'd1, 32'd0);
                else check("a_latency", 32'(cyc - acc_a), 32'(la.pop_front()));
            end
            ov_prev_a <= out_valid_a;
        end
    end

    // Monitor for the 12-round instance.
    always @(negedge clk) begin
        rnd_t e;
        if (rst) begin
            ov_prev_b <= 1'b0;
        end else begin
            if (load_en_b) acc_b <= cyc;
            if (round_en_b) begin
                if (qb.size() == 0) check("b_unexpected_round", 32'd1, 32'd0);
                else begin
                    e = qb.pop_front();
                    check("b_round_t", 32'(t_b), 32'(e.t));
                    check("b_last_round", 32'(last_b), 32'(e.last));
                end
            end else if (last_b) begin
                check("b_last_without_round", 32'd1, 32'd0);
            end
            if (out_valid_b && !ov_prev_b) begin
                if (lb.size() == 0) check("b_unexpected_out_valid", 32'd1, 32'd0);
                else check("b_latency", 32'(cyc - acc_b), 32'(lb.pop_front()));
            end
            ov_prev_b <= out_valid_b;
        end
    end

    initial begin
        rst = 1'b1;
        in_valid_a = 1'b0; hold_a = 1'b0; abort_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; hold_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1;

        // Reset: outputs while rst is high and in the first cycle after.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_t_a", 32'(t_a), 32'd0);
        check("rst_t_b", 32'(t_b), 32'd12);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_round_en", 32'(round_en_a), 32'd0);
        next_drive();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready_a), 32'd1);
        check("post_rst_t", 32'(t_a), 32'd0);
        check("post_rst_busy", 32'(busy_a), 32'd0);
        check("post_rst_load_en", 32'(load_en_a), 32'd0);
        check("post_rst_in_ready_b", 32'(in_ready_b), 32'd1);

        // Single 24-round request, no hold.
        next_drive();
        push_rounds(0, 0, 23);
        la.push_back(25);
        in_valid_a = 1'b1;
        @(negedge clk);
        check("t1_load_en", 32'(load_en_a), 32'd1);
        next_drive();
        in_valid_a = 1'b0;
        wait_idle_a("t1_complete");

        // Hold for three cycles while t is 10.
        next_drive();
        push_rounds(0, 0, 23);
        la.push_back(28);
        in_valid_a = 1'b1;
        next_drive();
        in_valid_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        hold_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_t", 32'(t_a), 32'd10);
            check("hold_round_en", 32'(round_en_a), 32'd0);
            next_drive();
        end
        hold_a = 1'b0;
        wait_idle_a("t2_complete");

        // Consumer stalls in DONE, then a back-to-back request.
        next_drive();
        out_ready_a = 1'b0;
        push_rounds(0, 0, 23);
        la.push_back(25);
        in_valid_a = 1'b1;
        next_drive();
        in_valid_a = 1'b0;
        wait_ov_a("t3_out_valid_seen");
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(out_valid_a), 32'd1);
            check("stall_in_ready", 32'(in_ready_a), 32'd0);
            @(negedge clk);
        end
        next_drive();
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        push_rounds(0, 0, 23);
        la.push_back(25);
        @(negedge clk);
        check("b2b_load_en", 32'(load_en_a), 32'd1);
        check("b2b_in_ready", 32'(in_ready_a), 32'd1);
        next_drive();
        in_valid_a = 1'b0;
        @(negedge clk);
        check("b2b_t", 32'(t_a), 32'd0);
        check("b2b_round_en", 32'(round_en_a), 32'd1);
        wait_idle_a("t3_complete");

        // Abort at t=15, with in_valid also raised in the abort cycle.
        next_drive();
        push_rounds(0, 0, 14);
        in_valid_a = 1'b1;
        next_drive();
        in_valid_a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        abort_a    = 1'b1;
        in_valid_a = 1'b1;
        @(negedge clk);
        check("abort_t", 32'(t_a), 32'd15);
        check("abort_round_en", 32'(round_en_a), 32'd0);
        check("abort_in_ready", 32'(in_ready_a), 32'd0);
        check("abort_load_en", 32'(load_en_a), 32'd0);
        next_drive();
        abort_a    = 1'b0;
        in_valid_a = 1'b0;
        @(negedge clk);
        check("post_abort_busy", 32'(busy_a), 32'd0);
        check("post_abort_t", 32'(t_a), 32'd0);
        check("post_abort_in_ready", 32'(in_ready_a), 32'd1);
        repeat (30) @(negedge clk);

        // Reset in the middle of a run at t=5, then a clean restart.
        next_drive();
        push_rounds(0, 0, 4);
        in_valid_a = 1'b1;
        next_drive();
        in_valid_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_round_en", 32'(round_en_a), 32'd0);
        check("midrst_in_ready", 32'(in_ready_a), 32'd0);
        next_drive();
        rst = 1'b0;
        @(negedge clk);
        check("after_midrst_busy", 32'(busy_a), 32'd0);
        check("after_midrst_t", 32'(t_a), 32'd0);
        check("after_midrst_out_valid", 32'(out_valid_a), 32'd0);
        check("after_midrst_in_ready", 32'(in_ready_a), 32'd1);
        check("after_midrst_t_b", 32'(t_b), 32'd12);
        next_drive();
        push_rounds(0, 0, 23);
        la.push_back(25);
        in_valid_a = 1'b1;
        next_drive();
        in_valid_a = 1'b0;
        wait_idle_a("t5_complete");

        // Twelve-round instance: t runs 12..23.
        next_drive();
        push_rounds(1, 12, 23);
        lb.push_back(13);
        in_valid_b = 1'b1;
        @(negedge clk);
        check("b_load_en", 32'(load_en_b), 32'd1);
        next_drive();
        in_valid_b = 1'b0;
        wait_idle_b("b_complete");

        repeat (3) @(negedge clk);
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("la_drained", 32'(la.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        check("lb_drained", 32'(lb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
